// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds the FSM state, port-select encoding and the word geometry.
package mem_arbiter_pkg;

    localparam int unsigned WORD_W       = 64;
    localparam int unsigned ADDR_W       = 64;
    localparam int unsigned DEPTH_DEF    = 8192;
    localparam int unsigned MAX_WAIT_DEF = 4;
    localparam int unsigned STARVE_W     = 3;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic {
        PORT_IF,
        PORT_DM
    } port_t;

    function automatic logic addr_oor(input logic [ADDR_W-1:0] addr, input int unsigned depth);
        return addr >= ADDR_W'(depth);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the arbiter: fetch port, data port and shared status.
// The arbiter uses the slave view; a requester model uses the master view.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [WORD_W-1:0] if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [WORD_W-1:0] dm_wdata;
    logic              dm_ack;
    logic [WORD_W-1:0] dm_rdata;
    logic              adr_err;
    logic              busy;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        output if_ack, if_rdata, dm_ack, dm_rdata, adr_err, busy
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        input  if_ack, if_rdata, dm_ack, dm_rdata, adr_err, busy
    );

endinterface

// File: rtl/mem_arbiter_prio.sv
// Grant decision between fetch and data ports with a starvation counter.
// Data port wins ties until the fetch port has lost MAX_WAIT times in a row.
module mem_arbiter_prio
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_arb_en,
    input  logic  i_if_req,
    input  logic  i_dm_req,
    output port_t o_grant
);

    logic [STARVE_W-1:0] r_starve;
    logic                w_force_if;

    assign w_force_if = (r_starve == STARVE_W'(MAX_WAIT));

    always_comb begin
        o_grant = PORT_IF;
        if (i_dm_req && !(i_if_req && w_force_if)) begin
            o_grant = PORT_DM;
        end
    end

    // Counts only losses with the fetch port actually waiting; saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (i_arb_en) begin
            if (o_grant == PORT_IF) begin
                r_starve <= '0;
            end else if (i_if_req && (r_starve < STARVE_W'(MAX_WAIT))) begin
                r_starve <= r_starve + STARVE_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port single-word memory arbiter: IDLE latches the winner, ACCESS
// performs the read or write, RESP presents a one-cycle ack with data.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t            r_state;
    port_t             r_port;
    logic              r_we;
    logic [IDX_W-1:0]  r_idx;
    logic [WORD_W-1:0] r_wdata;
    logic              r_oor;
    logic              r_if_ack;
    logic              r_dm_ack;
    logic [WORD_W-1:0] r_if_rdata;
    logic [WORD_W-1:0] r_dm_rdata;
    logic              r_adr_err;
    logic              r_busy;
    logic [WORD_W-1:0] r_mem [DEPTH];

    port_t             w_grant;
    logic              w_any_req;
    logic              w_arb_en;
    logic              w_mem_we;
    logic [WORD_W-1:0] w_rd_word;

    assign w_any_req = bus.if_req | bus.dm_req;
    assign w_arb_en  = (r_state == IDLE) && w_any_req;
    assign w_mem_we  = (r_state == ACCESS) && r_we && !r_oor;
    assign w_rd_word = (r_we || r_oor) ? '0 : r_mem[r_idx];

    mem_arbiter_prio #(
        .MAX_WAIT (MAX_WAIT)
    ) u_prio (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_arb_en (w_arb_en),
        .i_if_req (bus.if_req),
        .i_dm_req (bus.dm_req),
        .o_grant  (w_grant)
    );

    // Storage has no reset; an async reset moves the FSM out of ACCESS, which blocks the commit.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_port     <= PORT_IF;
            r_we       <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_oor      <= 1'b0;
            r_if_ack   <= 1'b0;
            r_dm_ack   <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
            r_adr_err  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state <= ACCESS;
                        r_busy  <= 1'b1;
                        r_port  <= w_grant;
                        if (w_grant == PORT_DM) begin
                            r_we    <= bus.dm_we;
                            r_idx   <= bus.dm_addr[IDX_W-1:0];
                            r_wdata <= bus.dm_wdata;
                            r_oor   <= addr_oor(bus.dm_addr, DEPTH);
                        end else begin
                            r_we    <= 1'b0;
                            r_idx   <= bus.if_addr[IDX_W-1:0];
                            r_wdata <= '0;
                            r_oor   <= addr_oor(bus.if_addr, DEPTH);
                        end
                    end
                end
                ACCESS: begin
                    r_state    <= RESP;
                    r_if_ack   <= (r_port == PORT_IF);
                    r_dm_ack   <= (r_port == PORT_DM);
                    r_if_rdata <= (r_port == PORT_IF) ? w_rd_word : '0;
                    r_dm_rdata <= (r_port == PORT_DM) ? w_rd_word : '0;
                    r_adr_err  <= r_oor;
                end
                RESP: begin
                    r_state    <= IDLE;
                    r_busy     <= 1'b0;
                    r_if_ack   <= 1'b0;
                    r_dm_ack   <= 1'b0;
                    r_if_rdata <= '0;
                    r_dm_rdata <= '0;
                    r_adr_err  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.if_ack   = r_if_ack;
    assign bus.dm_ack   = r_dm_ack;
    assign bus.if_rdata = r_if_rdata;
    assign bus.dm_rdata = r_dm_rdata;
    assign bus.adr_err  = r_adr_err;
    assign bus.busy     = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a rule-level model predicts each grant
// and its response; a monitor compares whenever the DUT acks.
module tb_mem_arbiter;

    localparam int unsigned TB_DEPTH    = 8192;
    localparam int unsigned TB_MAX_WAIT = 4;

    typedef struct {
        bit          dm;
        logic [63:0] rdata;
        bit          err;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .DEPTH    (TB_DEPTH),
        .MAX_WAIT (TB_MAX_WAIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks;
    int          errors;
    exp_t        q[$];
    int          head;
    int          flush_mark;
    bit          ack_order[$];
    logic [63:0] mem_m [logic [63:0]];
    int          cyc;
    int          free_cyc;
    int          last_grant;
    int          starve;
    bit          pend_v;
    logic [63:0] pend_a;
    logic [63:0] pend_d;
    int          pend_cyc;
    int          busy_cnt;
    int          ifack_cnt;
    int          dmack_cnt;
    logic [63:0] oor_list [4];
    logic [63:0] rd0, rd1, rd2;
    bit          e0, e1, e2;
    bit          pat [11];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] init_val(input logic [63:0] a);
        return 64'h1234_5678_0000_0000 ^ (a * 64'h9E37);
    endfunction

    function automatic logic [63:0] pick_addr();
        int unsigned r;
        r = $urandom_range(0, 15);
        if (r < 2) return oor_list[$urandom_range(0, 3)];
        if (r < 10) return 64'($urandom_range(0, 15));
        return 64'($urandom_range(8184, 8191));
    endfunction

    task automatic model_flush();
        flush_mark = q.size();
        pend_v     = 1'b0;
        starve     = 0;
        free_cyc   = 0;
        last_grant = -100;
    endtask

    // One grant per three edges at most; dm wins ties unless fetch has lost MAX_WAIT times.
    task automatic model_edge();
        logic [63:0] a, d, rd;
        bit          we, dmw, err;
        if (pend_v && cyc == pend_cyc) begin
            mem_m[pend_a] = pend_d;
            pend_v = 1'b0;
        end
        if (cyc >= free_cyc && (bus.if_req || bus.dm_req)) begin
            dmw = bus.dm_req && !(bus.if_req && starve == int'(TB_MAX_WAIT));
            if (dmw) begin
                a  = bus.dm_addr;
                we = bus.dm_we;
                d  = bus.dm_wdata;
                if (bus.if_req && starve < int'(TB_MAX_WAIT)) starve++;
            end else begin
                a  = bus.if_addr;
                we = 1'b0;
                d  = '0;
                starve = 0;
            end
            err = (a >= 64'(TB_DEPTH));
            rd  = '0;
            if (!we && !err && mem_m.exists(a)) rd = mem_m[a];
            if (we && !err) begin
                pend_v   = 1'b1;
                pend_a   = a;
                pend_d   = d;
                pend_cyc = cyc + 1;
            end
            q.push_back('{dm: dmw, rdata: rd, err: err, cyc: cyc});
            free_cyc   = cyc + 3;
            last_grant = cyc;
        end
    endtask

    task automatic mon_negedge();
        exp_t e;
        bit   busy_exp;
        if (head < flush_mark) head = flush_mark;
        busy_exp = (rst_n === 1'b1) && ((cyc - last_grant) < 2);
        chk("busy", 64'(bus.busy), 64'(busy_exp));
        if (bus.busy)   busy_cnt++;
        if (bus.if_ack) ifack_cnt++;
        if (bus.dm_ack) dmack_cnt++;
        if (bus.if_ack || bus.dm_ack) begin
            if (head >= q.size()) begin
                chk("unexpected_ack", {62'd0, bus.if_ack, bus.dm_ack}, 64'd0);
            end else begin
                e = q[head];
                head++;
                chk("ack_if", 64'(bus.if_ack), 64'(!e.dm));
                chk("ack_dm", 64'(bus.dm_ack), 64'(e.dm));
                chk("rdata", e.dm ? bus.dm_rdata : bus.if_rdata, e.rdata);
                chk("other_rdata", e.dm ? bus.if_rdata : bus.dm_rdata, 64'd0);
                chk("adr_err", 64'(bus.adr_err), 64'(e.err));
                chk("latency", 64'(cyc), 64'(e.cyc + 1));
                ack_order.push_back(bus.dm_ack);
            end
        end else begin
            chk("adr_err_idle", 64'(bus.adr_err), 64'd0);
            chk("if_rdata_idle", bus.if_rdata, 64'd0);
            chk("dm_rdata_idle", bus.dm_rdata, 64'd0);
        end
    endtask

    task automatic if_op(input logic [63:0] a, input int reps, output logic [63:0] rd, output bit err);
        int got = 0;
        int n   = 0;
        rd  = '0;
        err = 1'b0;
        @(negedge clk);
        #1;
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        while (got < reps && n < 100) begin
            @(negedge clk);
            #1;
            n++;
            if (bus.if_ack) begin
                got++;
                rd  = bus.if_rdata;
                err = bus.adr_err;
            end
        end
        bus.if_req = 1'b0;
        chk("if_done", 64'(got), 64'(reps));
    endtask

    task automatic dm_op(input bit we, input logic [63:0] a, input logic [63:0] d, input int reps,
                         output logic [63:0] rd, output bit err);
        int got = 0;
        int n   = 0;
        rd  = '0;
        err = 1'b0;
        @(negedge clk);
        #1;
        bus.dm_req   = 1'b1;
        bus.dm_we    = we;
        bus.dm_addr  = a;
        bus.dm_wdata = d;
        while (got < reps && n < 100) begin
            @(negedge clk);
            #1;
            n++;
            if (bus.dm_ack) begin
                got++;
                rd  = bus.dm_rdata;
                err = bus.adr_err;
            end
        end
        bus.dm_req = 1'b0;
        chk("dm_done", 64'(got), 64'(reps));
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_if_ack"}, 64'(bus.if_ack), 64'd0);
        chk({tag, "_dm_ack"}, 64'(bus.dm_ack), 64'd0);
        chk({tag, "_if_rdata"}, bus.if_rdata, 64'd0);
        chk({tag, "_dm_rdata"}, bus.dm_rdata, 64'd0);
        chk({tag, "_adr_err"}, 64'(bus.adr_err), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int s;
        int n;
        int b0, i0, d0;
        checks = 0;
        errors = 0;
        head   = 0;
        cyc    = 0;
        model_flush();
        busy_cnt  = 0;
        ifack_cnt = 0;
        dmack_cnt = 0;
        oor_list[0] = 64'd8192;
        oor_list[1] = 64'd8193;
        oor_list[2] = 64'd70000;
        oor_list[3] = 64'hFFFF_FFFF_FFFF_FFFF;
        pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        rst_n        = 1'b0;
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;

        fork
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    model_flush();
                end else begin
                    cyc++;
                    model_edge();
                end
            end
            forever begin
                @(negedge clk);
                mon_negedge();
            end
        join_none

        repeat (2) @(negedge clk);
        #1;
        chk_outputs_zero("reset");
        rst_n = 1'b1;

        for (int a = 0; a < 16; a++) dm_op(1'b1, 64'(a), init_val(64'(a)), 1, rd0, e0);
        for (int a = 8184; a < 8192; a++) dm_op(1'b1, 64'(a), init_val(64'(a)), 1, rd0, e0);

        dm_op(1'b1, 64'd10, 64'hDEAD, 1, rd0, e0);
        if_op(64'd10, 1, rd0, e0);
        chk("raw_if_rdata", rd0, 64'hDEAD);
        chk("raw_if_err", 64'(e0), 64'd0);

        dm_op(1'b0, 64'd8192, '0, 1, rd0, e0);
        chk("oor_err", 64'(e0), 64'd1);
        chk("oor_rdata", rd0, 64'd0);
        dm_op(1'b0, 64'd8191, '0, 1, rd0, e0);
        chk("top_err", 64'(e0), 64'd0);
        chk("top_rdata", rd0, init_val(64'd8191));

        b0 = busy_cnt;
        i0 = ifack_cnt;
        d0 = dmack_cnt;
        if_op(64'd0, 1, rd0, e0);
        repeat (4) @(negedge clk);
        #1;
        chk("single_busy_cycles", 64'(busy_cnt - b0), 64'd2);
        chk("single_if_ack_cycles", 64'(ifack_cnt - i0), 64'd1);
        chk("single_dm_ack_cycles", 64'(dmack_cnt - d0), 64'd0);
        chk("single_rdata", rd0, init_val(64'd0));

        s = ack_order.size();
        @(negedge clk);
        #1;
        bus.if_req  = 1'b1;
        bus.if_addr = 64'd3;
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 64'd4;
        n = 0;
        while ((ack_order.size() - s) < 11 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
            if ((ack_order.size() - s) == 10) bus.if_req = 1'b0;
        end
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        chk("contention_acks", 64'(ack_order.size() - s), 64'd11);
        for (int i = 0; i < 11; i++) begin
            if (s + i < ack_order.size()) chk($sformatf("order_%0d", i), 64'(ack_order[s + i]), 64'(pat[i]));
        end

        @(negedge clk);
        #1;
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_addr  = 64'd5;
        bus.dm_wdata = 64'd1;
        @(negedge clk);
        #1;
        chk("abort_in_access", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("abort");
        bus.dm_req = 1'b0;
        bus.dm_we  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        dm_op(1'b0, 64'd5, '0, 1, rd0, e0);
        chk("abort_keeps_old", rd0, init_val(64'd5));

        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if_op(pick_addr(), int'($urandom_range(1, 2)), rd1, e1);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    dm_op(1'($urandom_range(0, 1)), pick_addr(), {$urandom, $urandom},
                          int'($urandom_range(1, 2)), rd2, e2);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
        join

        repeat (10) @(negedge clk);
        #1;
        chk("drain", 64'(head), 64'(q.size()));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
